// File: rtl/flow_reg_pkg.sv
// Shared types and constants for the flow/temperature regulator.
// Holds the level/state encodings, duty targets and sample range limits.
package flow_reg_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        LVL_OFF  = 2'd0,
        LVL_LOW  = 2'd1,
        LVL_MID  = 2'd2,
        LVL_HIGH = 2'd3
    } level_t;

    localparam logic [7:0] DUTY_OFF  = 8'd0;
    localparam logic [7:0] DUTY_LOW  = 8'd85;
    localparam logic [7:0] DUTY_MID  = 8'd170;
    localparam logic [7:0] DUTY_HIGH = 8'd255;

    localparam logic [7:0] TEMP_MAX  = 8'd50;
    localparam logic [7:0] HUM_MIN   = 8'd20;
    localparam logic [7:0] HUM_MAX   = 8'd90;
    localparam logic [1:0] BAD_LIMIT = 2'd3;

    // Number of thresholds (a <= b <= c) that t meets or exceeds.
    function automatic logic [1:0] thr_count(input logic [7:0] t, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] c);
        logic [1:0] n;
        n = 2'd0;
        if (t >= a) n = n + 2'd1;
        if (t >= b) n = n + 2'd1;
        if (t >= c) n = n + 2'd1;
        return n;
    endfunction

    function automatic logic [7:0] level_duty(input level_t l);
        logic [7:0] d;
        case (l)
            LVL_OFF:  d = DUTY_OFF;
            LVL_LOW:  d = DUTY_LOW;
            LVL_MID:  d = DUTY_MID;
            default:  d = DUTY_HIGH;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// PWM generator: prescaled 8-bit counter with a duty shadow that only reloads
// on the 255->0 wrap, so a duty change never shortens or splits a period.
module pwm_gen #(
    parameter int PWM_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] duty,
    output logic       pwm_out
);

    logic [31:0] pre_q;
    logic [7:0]  cnt_q;
    logic [7:0]  shadow_q;
    logic        tick;

    assign tick = (pre_q == 32'(PWM_DIV - 1));

    // pwm_out is registered so the pin never sees comparator glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q    <= 32'd0;
            cnt_q    <= 8'd0;
            shadow_q <= 8'd0;
            pwm_out  <= 1'b0;
        end else begin
            pre_q <= tick ? 32'd0 : pre_q + 32'd1;
            if (tick) begin
                cnt_q <= cnt_q + 8'd1;
                if (cnt_q == 8'hFF) shadow_q <= duty;
            end
            pwm_out <= (shadow_q == 8'hFF) || (cnt_q < shadow_q);
        end
    end

endmodule

// File: rtl/flow_temp_regulator.sv
// Fan/flow regulator: hysteretic level select, ramped duty, PWM drive, fault fallback.
// Optional humidity boost is enabled by defining FLOW_HUM_BOOST_EN.
module flow_temp_regulator
    import flow_reg_pkg::*;
#(
    parameter int PWM_DIV   = 4,
    parameter int RAMP_DIV  = 1024,
    parameter int STALE_CYC = 75_000_000,
    parameter int T_LOW     = 20,
    parameter int T_MID     = 25,
    parameter int T_HIGH    = 30,
    parameter int HYST      = 1,
    parameter int HUM_TH    = 70
) (
    input  logic       col_clk,
    input  logic       sys_rst,
    input  logic       sample_valid,
    input  logic       sample_err,
    input  logic [7:0] temp_in,
    input  logic [7:0] hum_in,
    output logic [1:0] level,
    output logic [7:0] duty,
    output logic       pwm_out,
    output logic       fault
);

    // sample_valid is a one-cycle strobe with no back-pressure: temp_in,
    // hum_in and sample_err are consumed on exactly the cycle it is high.
    localparam logic [31:0] STALE_MAX  = 32'(STALE_CYC);
    localparam logic [31:0] STALE_LAST = 32'(STALE_CYC - 1);
    localparam logic [31:0] RAMP_LAST  = 32'(RAMP_DIV - 1);

    state_t      state_q, state_d;
    level_t      base_q, base_d, eff_lvl;
    logic [1:0]  bad_cnt_q;
    logic [31:0] stale_q;
    logic [31:0] ramp_q;
    logic [7:0]  duty_q, target;
    logic [1:0]  up, down;
    logic        good, bad, expire, ramp_tick;

    assign good = sample_valid && !sample_err && (temp_in <= TEMP_MAX) &&
                  (hum_in >= HUM_MIN) && (hum_in <= HUM_MAX);
    assign bad  = sample_valid && !good;

    // A good sample on the expiry cycle masks the timeout.
    assign expire    = !good && (stale_q >= STALE_LAST);
    assign ramp_tick = (ramp_q == RAMP_LAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (!good && ((bad && bad_cnt_q == BAD_LIMIT - 2'd1) || expire))
                          state_d = ST_FAULT;
            default:  if (good) state_d = ST_RUN;
        endcase
    end

    always_comb begin
        up     = thr_count(temp_in, 8'(T_LOW), 8'(T_MID), 8'(T_HIGH));
        down   = thr_count(temp_in, 8'(T_LOW - HYST), 8'(T_MID - HYST), 8'(T_HIGH - HYST));
        base_d = base_q;
        if (up > base_q)        base_d = level_t'(up);
        else if (down < base_q) base_d = level_t'(down);
    end

`ifdef FLOW_HUM_BOOST_EN
    logic boost_q;

    always_ff @(posedge col_clk) begin
        if (sys_rst)   boost_q <= 1'b0;
        else if (good) boost_q <= (hum_in >= 8'(HUM_TH));
    end

    // Boost shifts only the effective level; hysteresis keeps tracking base_q.
    always_comb begin
        eff_lvl = base_q;
        if (state_q == ST_FAULT)               eff_lvl = LVL_HIGH;
        else if (boost_q && base_q != LVL_HIGH) eff_lvl = level_t'(base_q + 2'd1);
    end
`else
    always_comb begin
        eff_lvl = base_q;
        if (state_q == ST_FAULT) eff_lvl = LVL_HIGH;
    end
`endif

    assign target = level_duty(eff_lvl);

    always_ff @(posedge col_clk) begin
        if (sys_rst) begin
            state_q   <= ST_RUN;
            base_q    <= LVL_OFF;
            bad_cnt_q <= 2'd0;
            stale_q   <= 32'd0;
            ramp_q    <= 32'd0;
            duty_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            ramp_q  <= ramp_tick ? 32'd0 : ramp_q + 32'd1;
            if (good) begin
                base_q    <= base_d;
                bad_cnt_q <= 2'd0;
                stale_q   <= 32'd0;
            end else begin
                if (bad && bad_cnt_q != BAD_LIMIT) bad_cnt_q <= bad_cnt_q + 2'd1;
                if (stale_q != STALE_MAX)          stale_q   <= stale_q + 32'd1;
            end
            // Fault bypasses the ramp so full flow is applied immediately.
            if (state_d == ST_FAULT)                       duty_q <= DUTY_HIGH;
            else if (ramp_tick && duty_q < target)         duty_q <= duty_q + 8'd1;
            else if (ramp_tick && duty_q > target)         duty_q <= duty_q - 8'd1;
        end
    end

    pwm_gen #(
        .PWM_DIV (PWM_DIV)
    ) u_pwm (
        .clk     (col_clk),
        .rst     (sys_rst),
        .duty    (duty_q),
        .pwm_out (pwm_out)
    );

    assign level = eff_lvl;
    assign duty  = duty_q;
    assign fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_flow_temp_regulator.sv
// Directed bench for flow_temp_regulator: level table, ramp, PWM wrap, fault and stale timeout.
// Inputs change and outputs are sampled on the falling edge of col_clk.
module tb_flow_temp_regulator;

    typedef struct {
        logic [7:0] temp;
        logic [7:0] hum;
        logic       err;
        logic [1:0] exp_lvl;
        logic [1:0] exp_lvl_boost;
    } vec_t;

    logic       col_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       sample_valid = 1'b0;
    logic       sample_err = 1'b0;
    logic [7:0] temp_in = 8'd0;
    logic [7:0] hum_in = 8'd0;
    logic [1:0] level;
    logic [7:0] duty;
    logic       pwm_out;
    logic       fault;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    vec_t vecs[20];

    flow_temp_regulator #(
        .PWM_DIV   (1),
        .RAMP_DIV  (4),
        .STALE_CYC (2000)
    ) dut (
        .col_clk      (col_clk),
        .sys_rst      (sys_rst),
        .sample_valid (sample_valid),
        .sample_err   (sample_err),
        .temp_in      (temp_in),
        .hum_in       (hum_in),
        .level        (level),
        .duty         (duty),
        .pwm_out      (pwm_out),
        .fault        (fault)
    );

    always #5 col_clk = ~col_clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // Called on a falling edge; the sample is captured on the next rising edge.
    task automatic send(input logic [7:0] t, input logic [7:0] h, input logic e);
        sample_valid = 1'b1;
        sample_err   = e;
        temp_in      = t;
        hum_in       = h;
        @(negedge col_clk);
        sample_valid = 1'b0;
        sample_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge col_clk);
    endtask

    task automatic do_reset(input string tag);
        sys_rst = 1'b1;
        @(negedge col_clk);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_duty"}, duty, 0);
        chk({tag, "_pwm"}, pwm_out, 0);
        chk({tag, "_fault"}, fault, 0);
        sys_rst = 1'b0;
    endtask

    initial begin
        int  hi_cnt;
        int  early_hi, mid_hi, late_hi;
        logic prev, found;

        vecs[0]  = '{8'd26, 8'd64, 1'b0, 2'd2, 2'd2};
        vecs[1]  = '{8'd25, 8'd64, 1'b0, 2'd2, 2'd2};
        vecs[2]  = '{8'd23, 8'd64, 1'b0, 2'd1, 2'd1};
        vecs[3]  = '{8'd24, 8'd64, 1'b0, 2'd1, 2'd1};
        vecs[4]  = '{8'd19, 8'd64, 1'b0, 2'd1, 2'd1};
        vecs[5]  = '{8'd18, 8'd64, 1'b0, 2'd0, 2'd0};
        vecs[6]  = '{8'd31, 8'd64, 1'b0, 2'd3, 2'd3};
        vecs[7]  = '{8'd29, 8'd64, 1'b0, 2'd3, 2'd3};
        vecs[8]  = '{8'd28, 8'd64, 1'b0, 2'd2, 2'd2};
        vecs[9]  = '{8'd50, 8'd20, 1'b0, 2'd3, 2'd3};
        vecs[10] = '{8'd51, 8'd50, 1'b0, 2'd3, 2'd3};
        vecs[11] = '{8'd10, 8'd90, 1'b0, 2'd0, 2'd1};
        vecs[12] = '{8'd10, 8'd91, 1'b0, 2'd0, 2'd1};
        vecs[13] = '{8'd10, 8'd19, 1'b0, 2'd0, 2'd1};
        vecs[14] = '{8'd20, 8'd50, 1'b0, 2'd1, 2'd1};
        vecs[15] = '{8'd40, 8'd50, 1'b1, 2'd1, 2'd1};
        vecs[16] = '{8'd0,  8'd50, 1'b0, 2'd0, 2'd0};
        vecs[17] = '{8'd26, 8'd75, 1'b0, 2'd2, 2'd3};
        vecs[18] = '{8'd26, 8'd70, 1'b0, 2'd2, 2'd3};
        vecs[19] = '{8'd26, 8'd69, 1'b0, 2'd2, 2'd2};

        @(negedge col_clk);
        do_reset("rst0");

        // Ramp up to MID and measure the steady PWM high time.
        send(8'd26, 8'd64, 1'b0);
        chk("t1_level", level, 2);
        idle(200);
        chk_range("t1_duty_mid", duty, 49, 51);
        idle(500);
        chk("t1_duty_final", duty, 170);
        idle(300);
        hi_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge col_clk);
            if (pwm_out) hi_cnt++;
        end
        chk("t1_pwm_high", hi_cnt, 170);

        // Hysteresis on the way down.
        send(8'd25, 8'd64, 1'b0);
        chk("t2_hold", level, 2);
        send(8'd23, 8'd64, 1'b0);
        chk("t2_drop", level, 1);
        idle(85 * 4 + 8);
        chk("t2_duty", duty, 85);
        idle(300);

        // Lock onto a PWM period start, then fault mid-period.
        prev  = pwm_out;
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge col_clk);
            if (!prev && pwm_out) found = 1'b1;
            prev = pwm_out;
        end
        chk("t5_sync_found", found, 1);
        if (found) begin
            early_hi = 0;
            mid_hi   = 0;
            late_hi  = 0;
            for (int t = 1; t < 512; t++) begin
                if (t == 100 || t == 102 || t == 104) begin
                    sample_valid = 1'b1;
                    sample_err   = 1'b1;
                    temp_in      = 8'd26;
                    hum_in       = 8'd50;
                end else begin
                    sample_valid = 1'b0;
                    sample_err   = 1'b0;
                end
                @(negedge col_clk);
                if (t < 85 && pwm_out)                early_hi++;
                if (t >= 85 && t < 256 && pwm_out)    mid_hi++;
                if (t >= 256 && pwm_out)              late_hi++;
                if (t == 103) chk("t3_no_fault_2bad", fault, 0);
                if (t == 104) begin
                    chk("t3_fault", fault, 1);
                    chk("t3_duty_jump", duty, 255);
                    chk("t3_level_high", level, 3);
                end
            end
            chk("t5_old_high", early_hi, 84);
            chk("t5_old_low", mid_hi, 0);
            chk("t3_pwm_const1", late_hi, 256);
        end

        send(8'd18, 8'd55, 1'b0);
        chk("t3_recover_fault", fault, 0);
        chk("t3_recover_level", level, 0);
        idle(255 * 4 + 8);
        chk("t3_duty_zero", duty, 0);

        // Stale timeout, then a good sample landing on the expiry cycle.
        send(8'd18, 8'd55, 1'b0);
        idle(1999);
        chk("t4_pre_expiry", fault, 0);
        idle(1);
        chk("t4_stale_fault", fault, 1);
        chk("t4_stale_duty", duty, 255);
        send(8'd22, 8'd50, 1'b0);
        chk("t4_recover", fault, 0);
        chk("t4_recover_level", level, 1);
        idle(1999);
        chk("t4_pre_expiry2", fault, 0);
        send(8'd22, 8'd50, 1'b0);
        chk("t4_good_wins", fault, 0);
        idle(2);
        chk("t4_still_run", fault, 0);

        // Level table from a fresh reset.
        do_reset("rst1");
        for (int i = 0; i < 20; i++) begin
`ifdef FLOW_HUM_BOOST_EN
            exp_q.push_back({6'd0, vecs[i].exp_lvl_boost});
`else
            exp_q.push_back({6'd0, vecs[i].exp_lvl});
`endif
            send(vecs[i].temp, vecs[i].hum, vecs[i].err);
            chk($sformatf("vec%0d_level", i), level, exp_q.pop_front());
            chk($sformatf("vec%0d_fault", i), fault, 0);
        end

        // Reset asserted while ramping.
        do_reset("rst2");
        send(8'd31, 8'd50, 1'b0);
        chk("t6_level", level, 3);
        idle(100);
        chk_range("t6_duty_ramping", duty, 24, 26);
        do_reset("rst_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
